// File: rtl/iob_asym_fifo_ctrl.sv
// Width-converting FIFO controller for an external asymmetric two-port RAM.
// Pointers and fill level count narrow words; data order is little-endian.
module iob_asym_fifo_ctrl #(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 4,
  localparam int unsigned MIN_W    = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int unsigned WN       = W_DATA_W / MIN_W,
  localparam int unsigned RN       = R_DATA_W / MIN_W,
  localparam int unsigned LOG_WN   = $clog2(WN),
  localparam int unsigned LOG_RN   = $clog2(RN),
  localparam int unsigned W_ADDR_W = ADDR_W - LOG_WN,
  localparam int unsigned R_ADDR_W = ADDR_W - LOG_RN,
  localparam int unsigned LVL_W    = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en_i,
  input  logic [W_DATA_W-1:0] w_data_i,
  output logic                w_full_o,
  input  logic                r_en_i,
  output logic [R_DATA_W-1:0] r_data_o,
  output logic                r_valid_o,
  output logic                r_empty_o,
  output logic [LVL_W-1:0]    level_o,
  output logic                ext_mem_w_en_o,
  output logic [W_ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [W_DATA_W-1:0] ext_mem_w_data_o,
  output logic                ext_mem_r_en_o,
  output logic [R_ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [R_DATA_W-1:0] ext_mem_r_data_i
);

  localparam int unsigned CAP      = 1 << ADDR_W;
  localparam int unsigned FULL_THR = CAP - WN;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_nxt_c;
  logic              r_valid;
  logic              push_c;
  logic              pop_c;

  // Flags come from the registered level only, so a concurrent pop never
  // makes room for a push in the same cycle (and vice versa).
  assign w_full_o  = (level > LVL_W'(FULL_THR));
  assign r_empty_o = (level < LVL_W'(RN));

  assign push_c = w_en_i & ~w_full_o;
  assign pop_c  = r_en_i & ~r_empty_o;

  assign ext_mem_w_en_o   = push_c;
  assign ext_mem_w_addr_o = wptr[ADDR_W-1:LOG_WN];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = pop_c;
  assign ext_mem_r_addr_o = rptr[ADDR_W-1:LOG_RN];

  assign r_data_o  = ext_mem_r_data_i;
  assign r_valid_o = r_valid;
  assign level_o   = level;

  // Net level change for this cycle's accepted push/pop.
  always_comb begin
    level_nxt_c = level;
    if (push_c) level_nxt_c = level_nxt_c + LVL_W'(WN);
    if (pop_c)  level_nxt_c = level_nxt_c - LVL_W'(RN);
  end

  // Capacity is a multiple of WN and RN, so plain modular wrap is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (push_c) wptr <= wptr + ADDR_W'(WN);
      if (pop_c)  rptr <= rptr + ADDR_W'(RN);
      level   <= level_nxt_c;
      r_valid <= pop_c;
    end
  end

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Bench for iob_asym_fifo_ctrl: 32->8 and 8->32 instances, behavioural RAMs,
// and a byte-queue reference model of the FIFO contents.
module tb_iob_asym_fifo_ctrl;

  logic clk;
  logic rst_n;

  // 32->8 instance
  logic        a_w_en, a_w_full, a_r_en, a_r_valid, a_r_empty;
  logic [31:0] a_w_data, a_mw_data;
  logic [7:0]  a_r_data, a_mr_data;
  logic [4:0]  a_level;
  logic        a_mw_en, a_mr_en;
  logic [1:0]  a_mw_addr;
  logic [3:0]  a_mr_addr;

  // 8->32 instance
  logic        b_w_en, b_w_full, b_r_en, b_r_valid, b_r_empty;
  logic [7:0]  b_w_data, b_mw_data;
  logic [31:0] b_r_data, b_mr_data;
  logic [4:0]  b_level;
  logic        b_mw_en, b_mr_en;
  logic [3:0]  b_mw_addr;
  logic [1:0]  b_mr_addr;

  iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .w_en_i(a_w_en), .w_data_i(a_w_data), .w_full_o(a_w_full),
    .r_en_i(a_r_en), .r_data_o(a_r_data), .r_valid_o(a_r_valid),
    .r_empty_o(a_r_empty), .level_o(a_level),
    .ext_mem_w_en_o(a_mw_en), .ext_mem_w_addr_o(a_mw_addr), .ext_mem_w_data_o(a_mw_data),
    .ext_mem_r_en_o(a_mr_en), .ext_mem_r_addr_o(a_mr_addr), .ext_mem_r_data_i(a_mr_data)
  );

  iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .w_en_i(b_w_en), .w_data_i(b_w_data), .w_full_o(b_w_full),
    .r_en_i(b_r_en), .r_data_o(b_r_data), .r_valid_o(b_r_valid),
    .r_empty_o(b_r_empty), .level_o(b_level),
    .ext_mem_w_en_o(b_mw_en), .ext_mem_w_addr_o(b_mw_addr), .ext_mem_w_data_o(b_mw_data),
    .ext_mem_r_en_o(b_mr_en), .ext_mem_r_addr_o(b_mr_addr), .ext_mem_r_data_i(b_mr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asymmetric RAMs stored as 16 bytes each, 1-cycle read latency
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  always @(posedge clk) begin
    if (a_mw_en)
      for (int k = 0; k < 4; k++) mem_a[{a_mw_addr, 2'(k)}] <= a_mw_data[8*k +: 8];
    if (a_mr_en) a_mr_data <= mem_a[a_mr_addr];
    if (b_mw_en) mem_b[b_mw_addr] <= b_mw_data;
    if (b_mr_en)
      b_mr_data <= {mem_b[{b_mr_addr, 2'd3}], mem_b[{b_mr_addr, 2'd2}],
                    mem_b[{b_mr_addr, 2'd1}], mem_b[{b_mr_addr, 2'd0}]};
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the 32->8 FIFO: drive, check comb enables, advance, check state
  task automatic cyc_a(input logic we, input logic [31:0] wd, input logic re,
                       output logic acc_push, output logic acc_pop, output logic [7:0] popped);
    logic [7:0] exp_byte;
    exp_byte = 8'h00;
    a_w_en = we; a_w_data = wd; a_r_en = re;
    #1;
    acc_push = we && (qa.size() <= 12);
    acc_pop  = re && (qa.size() >= 1);
    chk("a_mem_w_en", 32'(a_mw_en), 32'(acc_push));
    chk("a_mem_r_en", 32'(a_mr_en), 32'(acc_pop));
    if (acc_pop) exp_byte = qa.pop_front();
    if (acc_push) for (int k = 0; k < 4; k++) qa.push_back(wd[8*k +: 8]);
    @(posedge clk); #1;
    a_w_en = 1'b0; a_r_en = 1'b0;
    chk("a_r_valid", 32'(a_r_valid), 32'(acc_pop));
    if (acc_pop) chk("a_r_data", 32'(a_r_data), 32'(exp_byte));
    chk("a_level", 32'(a_level), 32'(qa.size()));
    chk("a_full", 32'(a_w_full), 32'(qa.size() > 12));
    chk("a_empty", 32'(a_r_empty), 32'(qa.size() < 1));
    popped = exp_byte;
  endtask

  // One clock of the 8->32 FIFO
  task automatic cyc_b(input logic we, input logic [7:0] wd, input logic re,
                       output logic acc_pop, output logic [31:0] popped);
    logic [31:0] exp_word;
    logic        acc_push;
    exp_word = 32'h0;
    b_w_en = we; b_w_data = wd; b_r_en = re;
    #1;
    acc_push = we && (qb.size() <= 15);
    acc_pop  = re && (qb.size() >= 4);
    chk("b_mem_w_en", 32'(b_mw_en), 32'(acc_push));
    chk("b_mem_r_en", 32'(b_mr_en), 32'(acc_pop));
    if (acc_pop) for (int k = 0; k < 4; k++) exp_word[8*k +: 8] = qb.pop_front();
    if (acc_push) qb.push_back(wd);
    @(posedge clk); #1;
    b_w_en = 1'b0; b_r_en = 1'b0;
    chk("b_r_valid", 32'(b_r_valid), 32'(acc_pop));
    if (acc_pop) chk("b_r_data", b_r_data, exp_word);
    chk("b_level", 32'(b_level), 32'(qb.size()));
    chk("b_full", 32'(b_w_full), 32'(qb.size() > 15));
    chk("b_empty", 32'(b_r_empty), 32'(qb.size() < 4));
    popped = exp_word;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ap, op, bop;
    logic [7:0]  pb;
    logic [31:0] pw, wd;
    int          pushes, got, budget;

    rst_n = 1'b0;
    a_w_en = 1'b0; a_w_data = '0; a_r_en = 1'b0;
    b_w_en = 1'b0; b_w_data = '0; b_r_en = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset state
    chk("rst_a_level", 32'(a_level), 32'd0);
    chk("rst_a_empty", 32'(a_r_empty), 32'd1);
    chk("rst_a_full", 32'(a_w_full), 32'd0);
    chk("rst_a_valid", 32'(a_r_valid), 32'd0);
    chk("rst_b_level", 32'(b_level), 32'd0);
    chk("rst_b_empty", 32'(b_r_empty), 32'd1);

    // 2: fill to full, then a rejected push
    cyc_a(1'b1, 32'h23222120, 1'b0, ap, op, pb);
    cyc_a(1'b1, 32'h27262524, 1'b0, ap, op, pb);
    cyc_a(1'b1, 32'h2B2A2928, 1'b0, ap, op, pb);
    cyc_a(1'b1, 32'h2F2E2D2C, 1'b0, ap, op, pb);
    chk("t2_level16", 32'(a_level), 32'd16);
    chk("t2_full", 32'(a_w_full), 32'd1);
    cyc_a(1'b1, 32'hDEADBEEF, 1'b0, ap, op, pb);
    chk("t2_rejected", 32'(ap), 32'd0);
    chk("t2_level_hold", 32'(a_level), 32'd16);

    // 3: drain in order, then pop while empty
    for (int i = 0; i < 16; i++) begin
      cyc_a(1'b0, 32'h0, 1'b1, ap, op, pb);
      chk("t3_byte", 32'(a_r_data), 32'h20 + 32'(i));
    end
    chk("t3_empty", 32'(a_r_empty), 32'd1);
    cyc_a(1'b0, 32'h0, 1'b1, ap, op, pb);
    chk("t3_no_valid", 32'(a_r_valid), 32'd0);

    // 4: level 8, simultaneous push+pop
    cyc_a(1'b1, 32'h33323130, 1'b0, ap, op, pb);
    cyc_a(1'b1, 32'h37363534, 1'b0, ap, op, pb);
    cyc_a(1'b1, 32'h3B3A3938, 1'b1, ap, op, pb);
    chk("t4_level11", 32'(a_level), 32'd11);
    chk("t4_byte", 32'(a_r_data), 32'h30);
    budget = 0;
    while (qa.size() > 0 && budget < 40) begin
      cyc_a(1'b0, 32'h0, 1'b1, ap, op, pb);
      budget++;
    end

    // 5: 40-byte stream across the pointer wrap, random push gaps
    pushes = 0; got = 0; budget = 0;
    while ((pushes < 10 || qa.size() > 0) && budget < 200) begin
      for (int k = 0; k < 4; k++) wd[8*k +: 8] = 8'(32'h20 + 32'(4*pushes + k));
      cyc_a((pushes < 10) && ($urandom_range(3) != 0), wd, qa.size() > 0, ap, op, pb);
      if (ap) pushes++;
      if (op) begin
        chk("t5_order", 32'(pb), 32'h20 + 32'(got));
        got++;
      end
      budget++;
    end
    chk("t5_count", 32'(got), 32'd40);
    chk("t5_in_budget", 32'(budget < 200), 32'd1);

    // Random traffic against the queue model
    for (int i = 0; i < 300; i++)
      cyc_a(1'($urandom), $urandom, 1'($urandom), ap, op, pb);

    // 6: 8->32 configuration
    cyc_b(1'b1, 8'h20, 1'b0, bop, pw);
    cyc_b(1'b1, 8'h21, 1'b0, bop, pw);
    cyc_b(1'b1, 8'h22, 1'b0, bop, pw);
    chk("t6_empty3", 32'(b_r_empty), 32'd1);
    cyc_b(1'b0, 8'h00, 1'b1, bop, pw);
    chk("t6_pop_ignored", 32'(b_r_valid), 32'd0);
    cyc_b(1'b1, 8'h23, 1'b0, bop, pw);
    chk("t6_not_empty", 32'(b_r_empty), 32'd0);
    cyc_b(1'b0, 8'h00, 1'b1, bop, pw);
    chk("t6_word", b_r_data, 32'h23222120);
    for (int i = 0; i < 8; i++) cyc_b(1'b1, 8'(8'h24 + i), 1'b0, bop, pw);
    cyc_b(1'b0, 8'h00, 1'b1, bop, pw);
    chk("t6_word2", b_r_data, 32'h27262524);
    chk("t6_valid_before_rst", 32'(b_r_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_level", 32'(b_level), 32'd0);
    chk("t6_rst_valid", 32'(b_r_valid), 32'd0);
    chk("t6_rst_empty", 32'(b_r_empty), 32'd1);
    chk("t6_rst_a_level", 32'(a_level), 32'd0);
    qa.delete();
    qb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc_b(1'b1, 8'h55, 1'b0, bop, pw);
    chk("t6_post_rst_level", 32'(b_level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
